// File: rtl/dsp_wb_seq_pkg.sv
// dsp_wb_seq_pkg: register map, FSM states and sizing shared by the DSP Wishbone sequencer
package dsp_wb_seq_pkg;
    localparam int MAX_SAMPLES = 32;
    localparam logic [31:0] OFS_TRIG = 32'h00;
    localparam logic [31:0] OFS_WSTB = 32'h04;
    localparam logic [31:0] OFS_WADR = 32'h08;
    localparam logic [31:0] OFS_WDAT = 32'h0C;
    localparam logic [31:0] OFS_RADR = 32'h10;
    localparam logic [31:0] OFS_STAT = 32'h10;
    localparam logic [31:0] OFS_RDAT = 32'h1C;
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_WAIT, S_LOAD_BUS, S_KICK, S_POLL,
        S_UNLOAD_BUS, S_UNLOAD_WAIT, S_DONE, S_ERROR
    } state_e;
endpackage

// File: rtl/dsp_wb_sequencer_if.sv
// dsp_wb_sequencer_if: Wishbone initiator bus plus sample/result streams of the sequencer
interface dsp_wb_sequencer_if;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic        in_valid_i, in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_data_o;
    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        output in_ready_o, out_valid_o, out_data_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, in_valid_i, in_data_i, out_ready_i
    );
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        input  in_ready_o, out_valid_o, out_data_o,
        output wb_dat_i, wb_ack_i, wb_err_i, in_valid_i, in_data_i, out_ready_i
    );
endinterface

// File: rtl/dsp_wb_xfer.sv
// dsp_wb_xfer: one classic Wishbone single transfer per request; ack watchdog under DSP_WB_SEQ_ACK_TIMEOUT_EN
module dsp_wb_xfer #(
    parameter int ACK_LIMIT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] wdat_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdat_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    logic        active_q, we_q, timeout;
    logic [31:0] adr_q, dat_q;

    assign err_o    = active_q && (wb_err_i || timeout);
    assign done_o   = active_q && wb_ack_i && !err_o;
    assign rdat_o   = wb_dat_i;
    assign wb_cyc_o = active_q;
    assign wb_stb_o = active_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;

`ifdef DSP_WB_SEQ_ACK_TIMEOUT_EN
    logic [31:0] wait_q;
    assign timeout = active_q && wait_q == 32'(ACK_LIMIT - 1);
    // count cycles the open transfer has been waiting; cleared once it ends
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) wait_q <= '0;
        else wait_q <= (active_q && !done_o && !err_o) ? wait_q + 32'd1 : '0;
`else
    logic unused_ack_limit;
    assign unused_ack_limit = ^ACK_LIMIT;
    assign timeout = 1'b0;
`endif

    // open a transfer on request and latch its fields; close it on ack/err so cyc drops for a cycle
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            active_q <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
        end else if (active_q) begin
            active_q <= !(done_o || err_o);
        end else if (req_i) begin
            active_q <= 1'b1;
            we_q     <= we_i;
            adr_q    <= adr_i;
            dat_q    <= wdat_i;
        end
endmodule

// File: rtl/dsp_wb_sequencer.sv
// dsp_wb_sequencer: loads samples into a DSP peripheral over Wishbone, kicks it, polls and unloads results; ack watchdog under DSP_WB_SEQ_ACK_TIMEOUT_EN
module dsp_wb_sequencer
    import dsp_wb_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          POLL_LIMIT = 1024,
    parameter int          ACK_LIMIT  = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic [5:0]        num_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    dsp_wb_sequencer_if.master bus
);
    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d, last_q, last_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] poll_q, poll_d, data_q, data_d, ofs, wdat, x_rdat;
    logic        err_q, err_d, req, we, x_done, x_err;

    assign busy_o          = !(state_q == S_IDLE || state_q == S_ERROR);
    assign done_o          = state_q == S_DONE;
    assign err_o           = err_q;
    assign bus.in_ready_o  = state_q == S_LOAD_WAIT;
    assign bus.out_valid_o = state_q == S_UNLOAD_WAIT;
    assign bus.out_data_o  = data_q;
    assign bus.wb_sel_o    = 4'hF;

    dsp_wb_xfer #(.ACK_LIMIT(ACK_LIMIT)) u_xfer (
        .clk_i(wb_clk_i), .rst_ni(wb_rst_ni), .req_i(req), .we_i(we),
        .adr_i(BASE_ADDR + ofs), .wdat_i(wdat), .done_o(x_done), .err_o(x_err), .rdat_o(x_rdat),
        .wb_adr_o(bus.wb_adr_o), .wb_dat_o(bus.wb_dat_o), .wb_cyc_o(bus.wb_cyc_o),
        .wb_stb_o(bus.wb_stb_o), .wb_we_o(bus.wb_we_o), .wb_dat_i(bus.wb_dat_i),
        .wb_ack_i(bus.wb_ack_i), .wb_err_i(bus.wb_err_i)
    );

    // job sequencing: each bus state steps through its transfers as the transfer engine completes them
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        step_d  = step_q;
        poll_d  = poll_q;
        data_d  = data_q;
        err_d   = err_q;
        req     = 1'b0;
        we      = 1'b1;
        ofs     = OFS_TRIG;
        wdat    = '0;
        case (state_q)
            S_IDLE, S_ERROR: if (start_i) begin
                state_d = S_LOAD_WAIT;
                idx_d   = '0;
                step_d  = '0;
                err_d   = 1'b0;
                last_d  = (num_i == 6'd0 || num_i > 6'(MAX_SAMPLES)) ? 6'(MAX_SAMPLES - 1) : num_i - 6'd1;
            end
            S_LOAD_WAIT: if (bus.in_valid_i) begin
                data_d  = bus.in_data_i;
                state_d = S_LOAD_BUS;
            end
            S_LOAD_BUS: begin
                req  = 1'b1;
                ofs  = step_q == 2'd0 ? OFS_WADR : step_q == 2'd1 ? OFS_WDAT : OFS_WSTB;
                wdat = step_q == 2'd0 ? {26'd0, idx_q} : step_q == 2'd1 ? data_q : {31'd0, step_q == 2'd2};
                if (x_done) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_d = idx_q == last_q ? S_KICK : S_LOAD_WAIT;
                        idx_d   = idx_q == last_q ? idx_q : idx_q + 6'd1;
                    end
                end
            end
            S_KICK: begin
                req  = 1'b1;
                wdat = {31'd0, step_q == 2'd0};
                if (x_done) begin
                    step_d  = step_q[0] ? 2'd0 : 2'd1;
                    state_d = step_q[0] ? S_POLL : S_KICK;
                    poll_d  = '0;
                end
            end
            S_POLL: begin
                req = 1'b1;
                we  = 1'b0;
                ofs = OFS_STAT;
                if (x_done) begin
                    poll_d = poll_q + 32'd1;
                    if (x_rdat[0]) begin
                        state_d = S_UNLOAD_BUS;
                        idx_d   = '0;
                        step_d  = '0;
                    end else if (poll_q == 32'(POLL_LIMIT - 1)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_UNLOAD_BUS: begin
                req  = 1'b1;
                we   = step_q == 2'd0;
                ofs  = step_q == 2'd0 ? OFS_RADR : OFS_RDAT;
                wdat = {26'd0, idx_q};
                if (x_done) begin
                    step_d  = step_q[0] ? 2'd0 : 2'd1;
                    data_d  = step_q[0] ? x_rdat : data_q;
                    state_d = step_q[0] ? S_UNLOAD_WAIT : S_UNLOAD_BUS;
                end
            end
            S_UNLOAD_WAIT: if (bus.out_ready_i) begin
                state_d = idx_q == last_q ? S_DONE : S_UNLOAD_BUS;
                idx_d   = idx_q == last_q ? idx_q : idx_q + 6'd1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (x_err) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
        end
    end

    // sequencer state; reset abandons any job and open transfer
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            step_q  <= '0;
            poll_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
endmodule

// File: tb/tb_dsp_wb_sequencer.sv
// tb_dsp_wb_sequencer: table-driven jobs against a DSP peripheral model with a result scoreboard
module tb_dsp_wb_sequencer;
    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct {
        int num; logic [31:0] base; int stall_idx; int stall_len; int status_after;
        int err_xfer; int ack_delay; bit exp_err; int exp_outs; int exp_strobes;
        int exp_polls; int exp_wait; bit chk_trace;
    } row_t;
    typedef struct { logic we; logic [31:0] ofs; logic [31:0] dat; } tr_t;

    logic       wb_clk_i = 1'b0, wb_rst_ni = 1'b0, start_i = 1'b0;
    logic [5:0] num_i = '0;
    logic       busy_o, done_o, err_o;
    int checks = 0, errors = 0;

    int ack_delay = 0, status_after = 0, err_xfer = 0, xfer_n = 0, wait_cnt = 0, max_wait = 0;
    int status_reads = 0, strobes = 0, polls = 0;
    logic [31:0] wa, wd, ra, mem [32], res [32];
    tr_t trace [$];
    logic [31:0] exp_q [$];
    row_t rows [9];

    dsp_wb_sequencer_if bus ();

    dsp_wb_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(8), .ACK_LIMIT(64)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start_i(start_i), .num_i(num_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus.master)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic row_t mk(int num, logic [31:0] base, int si, int sl, int sa, int ex, int ad,
                                bit ee, int eo, int es, int ep, int ew, bit ct);
        row_t r;
        r.num = num; r.base = base; r.stall_idx = si; r.stall_len = sl; r.status_after = sa;
        r.err_xfer = ex; r.ack_delay = ad; r.exp_err = ee; r.exp_outs = eo; r.exp_strobes = es;
        r.exp_polls = ep; r.exp_wait = ew; r.chk_trace = ct;
        return r;
    endfunction

    function automatic tr_t mt(logic we, logic [31:0] ofs, logic [31:0] dat);
        tr_t t;
        t.we = we; t.ofs = ofs; t.dat = dat;
        return t;
    endfunction

    // peripheral model and bus protocol monitor, acting on falling edges
    initial begin
        logic la, le, p_cyc, p_we;
        logic [31:0] p_adr, p_dat, ofs;
        la = 0; le = 0; p_cyc = 0; p_we = 0; p_adr = 0; p_dat = 0;
        bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_dat_i = 0;
        forever begin
            @(negedge wb_clk_i);
            la = bus.wb_ack_i; le = bus.wb_err_i;
            if (p_cyc && bus.wb_cyc_o && !la && !le)
                chk("bus_hold", {31'd0, bus.wb_adr_o == p_adr && bus.wb_dat_o == p_dat && bus.wb_we_o == p_we}, 1);
            if (p_cyc && (la || le)) chk("cyc_drop", bus.wb_cyc_o, 0);
            if (bus.in_ready_o) chk("load_wait_idle", bus.wb_cyc_o, 0);
            bus.wb_ack_i = 0; bus.wb_err_i = 0;
            if (bus.wb_cyc_o && bus.wb_stb_o && !la && !le) begin
                wait_cnt++;
                if (wait_cnt > max_wait) max_wait = wait_cnt;
                if (wait_cnt > ack_delay) begin
                    xfer_n++;
                    if (xfer_n == err_xfer) bus.wb_err_i = 1;
                    else begin
                        bus.wb_ack_i = 1;
                        ofs = bus.wb_adr_o - BASE;
                        trace.push_back(mt(bus.wb_we_o, ofs, bus.wb_dat_o));
                        if (bus.wb_we_o) begin
                            if (ofs == 32'h08) wa = bus.wb_dat_o;
                            if (ofs == 32'h0C) wd = bus.wb_dat_o;
                            if (ofs == 32'h10) ra = bus.wb_dat_o;
                            if (ofs == 32'h04 && bus.wb_dat_o == 1) begin mem[wa[4:0]] = wd; strobes++; end
                            if (ofs == 32'h00 && bus.wb_dat_o == 1) begin
                                polls = 0;
                                for (int i = 0; i < 32; i++) res[i] = ~mem[i] ^ 32'(i);
                            end
                        end else if (ofs == 32'h10) begin
                            status_reads++;
                            bus.wb_dat_i = {31'd0, polls >= status_after};
                            polls++;
                        end else if (ofs == 32'h1C) bus.wb_dat_i = res[ra[4:0]];
                    end
                end
            end else wait_cnt = 0;
            p_cyc = bus.wb_cyc_o; p_adr = bus.wb_adr_o; p_dat = bus.wb_dat_o; p_we = bus.wb_we_o;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {24'd0, busy_o, done_o, err_o, bus.in_ready_o, bus.out_valid_o,
                            bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 0);
        chk({tag, "_adr"}, bus.wb_adr_o, 0);
        chk({tag, "_dat"}, bus.wb_dat_o, 0);
        chk({tag, "_sel"}, bus.wb_sel_o, 4'hF);
    endtask

    task automatic check_trace(input logic [31:0] base);
        tr_t e [$];
        for (int i = 0; i < 4; i++) begin
            e.push_back(mt(1, 32'h08, i)); e.push_back(mt(1, 32'h0C, base + i));
            e.push_back(mt(1, 32'h04, 1)); e.push_back(mt(1, 32'h04, 0));
        end
        e.push_back(mt(1, 32'h00, 1)); e.push_back(mt(1, 32'h00, 0)); e.push_back(mt(0, 32'h10, 0));
        for (int i = 0; i < 4; i++) begin e.push_back(mt(1, 32'h10, i)); e.push_back(mt(0, 32'h1C, 0)); end
        chk("trace_len", trace.size(), e.size());
        for (int j = 0; j < e.size() && j < trace.size(); j++) begin
            chk("trace_we", trace[j].we, e[j].we);
            chk("trace_adr", trace[j].ofs, e[j].ofs);
            if (e[j].we) chk("trace_dat", trace[j].dat, e[j].dat);
        end
    endtask

    task automatic run_job(input row_t r);
        int n, k, outs, dones, stall_left, end_cnt;
        bit adv;
        logic [31:0] snap;
        n = r.num == 0 ? 32 : r.num;
        k = 0; outs = 0; dones = 0; stall_left = r.stall_len; end_cnt = -1; adv = 0; snap = 0;
        exp_q.delete(); trace.delete();
        ack_delay = r.ack_delay; status_after = r.status_after; err_xfer = r.err_xfer;
        xfer_n = 0; max_wait = 0; status_reads = 0; strobes = 0;
        for (int i = 0; i < 32; i++) res[i] = 32'hDEAD_0000 | 32'(i);
        @(negedge wb_clk_i);
        start_i = 1; num_i = 6'(r.num); bus.in_valid_i = 0; bus.out_ready_i = 1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge wb_clk_i);
            if (c == 0) begin
                start_i = 0;
                chk("busy_after_start", busy_o, 1);
                chk("err_cleared", err_o, 0);
            end
            if (adv) k++;
            bus.in_valid_i = k < n && $urandom_range(0, 3) != 0;
            bus.in_data_i = r.base + 32'(k);
            adv = bus.in_valid_i && bus.in_ready_o;
            if (adv) exp_q.push_back(~(r.base + 32'(k)) ^ 32'(k));
            if (bus.out_valid_o && outs == r.stall_idx && stall_left > 0) begin
                if (stall_left == r.stall_len) snap = bus.out_data_o;
                else chk("stall_data", bus.out_data_o, snap);
                chk("stall_bus_idle", bus.wb_cyc_o, 0);
                bus.out_ready_i = 0;
                stall_left--;
            end else bus.out_ready_i = 1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                outs++;
                if (exp_q.size() == 0) chk("unexpected_out", bus.out_data_o, 32'hx);
                else chk("out_data", bus.out_data_o, exp_q.pop_front());
            end
            if (done_o) dones++;
            if (end_cnt < 0 && (dones > 0 || err_o)) end_cnt = 3;
            if (end_cnt == 0) break;
            if (end_cnt > 0) end_cnt--;
        end
        bus.in_valid_i = 0;
        chk("job_finished", {31'd0, end_cnt == 0}, 1);
        chk("err_o", err_o, {31'd0, r.exp_err});
        chk("busy_end", busy_o, 0);
        chk("outputs", outs, r.exp_outs);
        chk("done_pulses", dones, {31'd0, !r.exp_err});
        chk("strobes", strobes, r.exp_strobes);
        chk("status_reads", status_reads, r.exp_polls);
        if (r.exp_wait > 0) chk("max_wait", max_wait, r.exp_wait);
        if (r.chk_trace) check_trace(r.base);
    endtask

    task automatic reset_mid_transfer();
        int c, activity;
        ack_delay = 1000; err_xfer = 0; xfer_n = 0;
        @(negedge wb_clk_i);
        start_i = 1; num_i = 6'd2; bus.in_valid_i = 1; bus.in_data_i = 32'h5A5A;
        @(negedge wb_clk_i);
        start_i = 0;
        c = 0;
        while (!bus.wb_cyc_o && c < 50) begin @(negedge wb_clk_i); c++; end
        chk("xfer_started", bus.wb_cyc_o, 1);
        repeat (5) @(negedge wb_clk_i);
        wb_rst_ni = 0;
        #1;
        chk_idle_outputs("mid_rst");
        @(negedge wb_clk_i);
        wb_rst_ni = 1; bus.in_valid_i = 0;
        activity = 0;
        repeat (30) begin @(negedge wb_clk_i); if (bus.wb_cyc_o || busy_o) activity++; end
        chk("no_resume", activity, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.in_valid_i = 0; bus.in_data_i = 0; bus.out_ready_i = 1;
        rows[0] = mk(4, 32'h1, -1, 0, 0, 0, 0, 0, 4, 4, 1, 0, 1);
        rows[1] = mk(0, 32'h100, -1, 0, 0, 0, 0, 0, 32, 32, 1, 0, 0);
        rows[2] = mk(3, 32'h55, -1, 0, 1000, 0, 0, 1, 0, 3, 8, 0, 0);
        rows[3] = mk(2, 32'h77, -1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0);
        rows[4] = mk(2, 32'h9000, -1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0);
        rows[5] = mk(5, 32'hABC0, 2, 10, 0, 0, 0, 0, 5, 5, 1, 0, 0);
`ifdef DSP_WB_SEQ_ACK_TIMEOUT_EN
        rows[6] = mk(1, 32'h33, -1, 0, 0, 0, 199, 1, 0, 0, 0, 64, 0);
`else
        rows[6] = mk(1, 32'h33, -1, 0, 0, 0, 199, 0, 1, 1, 1, 200, 0);
`endif
        rows[7] = mk(32, 32'hF000_0000, -1, 0, 0, 0, 0, 0, 32, 32, 1, 0, 0);
        rows[8] = mk(6, 32'h1234, -1, 0, 3, 0, 0, 0, 6, 6, 4, 0, 0);
        repeat (3) @(negedge wb_clk_i);
        chk_idle_outputs("por");
        wb_rst_ni = 1;
        repeat (2) @(negedge wb_clk_i);
        for (int i = 0; i < 9; i++) run_job(rows[i]);
        reset_mid_transfer();
        run_job(rows[4]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
